// File: rtl/boot_loader_wb128_if.sv
// Wishbone write-port bundle between the boot loader (master) and the
// 128-bit boot memory (slave).
interface boot_loader_wb128_if;
  logic [31:0]  adr;
  logic [15:0]  sel;
  logic         we;
  logic [127:0] dat;
  logic         cyc;
  logic         stb;
  logic         ack;
  logic         err;

  modport master (
    output adr, sel, we, dat, cyc, stb,
    input  ack, err
  );

  modport slave (
    input  adr, sel, we, dat, cyc, stb,
    output ack, err
  );
endinterface

// File: rtl/boot_loader_wb128.sv
// Boot loader: packs four 32-bit image words (first word = LSW) into a
// 128-bit line and writes each line over Wishbone to consecutive 16-byte
// addresses from BASE_ADDR. Aborts with a sticky error on bus error or ack
// timeout.
module boot_loader_wb128 #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LINES     = 1024,
  parameter int          TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_in0,
  input  logic        scan_in1,
  input  logic        scan_in2,
  input  logic        scan_in3,
  input  logic        scan_in4,
  input  logic        scan_enable,
  input  logic        test_mode,
  output logic        scan_out0,
  output logic        scan_out1,
  output logic        scan_out2,
  output logic        scan_out3,
  output logic        scan_out4,
  input  logic        i_start,
  input  logic [31:0] i_dat,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  boot_loader_wb128_if.master wb
);

  localparam int CW = $clog2(LINES + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t          state_reg,    state_next;
  logic [1:0]      word_idx_reg, word_idx_next;
  logic [CW-1:0]   line_cnt_reg, line_cnt_next;
  logic [TW-1:0]   tmo_cnt_reg,  tmo_cnt_next;
  logic [31:0]     adr_reg,      adr_next;
  logic [127:0]    dat_reg,      dat_next;
  logic            err_reg,      err_next;
  logic [CW-1:0]   line_cnt_inc;

  assign line_cnt_inc = line_cnt_reg + CW'(1);

  // Scan chain is only meaningful in test mode; in functional mode the
  // outputs sit at 0.
  assign scan_out0 = scan_enable & test_mode & scan_in0;
  assign scan_out1 = scan_enable & test_mode & scan_in1;
  assign scan_out2 = scan_enable & test_mode & scan_in2;
  assign scan_out3 = scan_enable & test_mode & scan_in3;
  assign scan_out4 = scan_enable & test_mode & scan_in4;

  // State and datapath registers; the async reset drops the bus cycle at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      word_idx_reg <= '0;
      line_cnt_reg <= '0;
      tmo_cnt_reg  <= '0;
      adr_reg      <= BASE_ADDR;
      dat_reg      <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      word_idx_reg <= word_idx_next;
      line_cnt_reg <= line_cnt_next;
      tmo_cnt_reg  <= tmo_cnt_next;
      adr_reg      <= adr_next;
      dat_reg      <= dat_next;
      err_reg      <= err_next;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_next    = state_reg;
    word_idx_next = word_idx_reg;
    line_cnt_next = line_cnt_reg;
    tmo_cnt_next  = tmo_cnt_reg;
    adr_next      = adr_reg;
    dat_next      = dat_reg;
    err_next      = err_reg;

    case (state_reg)
      // ERROR reports o_busy=0, so a start there is honoured like in IDLE.
      S_IDLE, S_ERROR: begin
        state_next = S_IDLE;
        if (i_start) begin
          err_next      = 1'b0;
          line_cnt_next = '0;
          word_idx_next = '0;
          tmo_cnt_next  = '0;
          adr_next      = BASE_ADDR;
          state_next    = S_FILL;
        end
      end

      S_FILL: begin
        if (i_valid) begin
          dat_next[{word_idx_reg, 5'd0} +: 32] = i_dat;
          word_idx_next = word_idx_reg + 2'd1;
          if (word_idx_reg == 2'd3) begin
            state_next = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        tmo_cnt_next = tmo_cnt_reg + TW'(1);
        // Error wins over a simultaneous ack.
        if (wb.err || (!wb.ack && tmo_cnt_reg == TW'(TIMEOUT - 1))) begin
          err_next     = 1'b1;
          tmo_cnt_next = '0;
          state_next   = S_ERROR;
        end else if (wb.ack) begin
          tmo_cnt_next  = '0;
          adr_next      = adr_reg + 32'd16;
          line_cnt_next = line_cnt_inc;
          state_next    = (line_cnt_inc == CW'(LINES)) ? S_DONE : S_FILL;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs decoded straight from the registered state.
  always_comb begin
    o_ready = (state_reg == S_FILL);
    o_busy  = (state_reg == S_FILL) || (state_reg == S_WRITE) || (state_reg == S_DONE);
    o_done  = (state_reg == S_DONE);
    o_err   = err_reg;
    wb.cyc  = (state_reg == S_WRITE);
    wb.stb  = (state_reg == S_WRITE);
    wb.we   = (state_reg == S_WRITE);
    wb.sel  = {16{state_reg == S_WRITE}};
    wb.adr  = adr_reg;
    wb.dat  = dat_reg;
  end

endmodule

// File: tb/tb_boot_loader_wb128.sv
// Bench for boot_loader_wb128: random word source, Wishbone slave with
// configurable latency/fault behaviour, and a line-level reference model.
module tb_boot_loader_wb128;
  localparam logic [31:0] BASE    = 32'h0000_0000;
  localparam int          NLINES  = 4;
  localparam int          TMO     = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_start = 1'b0;
  logic [31:0] i_dat = '0;
  logic        i_valid = 1'b0;
  logic        o_ready, o_busy, o_done, o_err;
  logic        so0, so1, so2, so3, so4;

  boot_loader_wb128_if wb();

  boot_loader_wb128 #(.BASE_ADDR(BASE), .LINES(NLINES), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .scan_in0(1'b0), .scan_in1(1'b0), .scan_in2(1'b0), .scan_in3(1'b0), .scan_in4(1'b0),
    .scan_enable(1'b0), .test_mode(1'b0),
    .scan_out0(so0), .scan_out1(so1), .scan_out2(so2), .scan_out3(so3), .scan_out4(so4),
    .i_start(i_start), .i_dat(i_dat), .i_valid(i_valid),
    .o_ready(o_ready), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .wb(wb)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Source and slave configuration.
  int valid_pct = 100;
  int max_delay = 0;
  int slave_mode = 0;   // 0 normal, 1 never ack, 2 error on err_line
  int err_line = 0;

  logic [31:0] src_q[$];
  bit          src_acc = 0;

  logic [31:0]  wr_adr[$];
  logic [127:0] wr_dat[$];
  logic [15:0]  wr_sel[$];
  logic         wr_we[$];
  int done_cnt = 0;
  int cyc_cycles = 0;

  logic [31:0] exp_words [0:4*NLINES-1];

  // Stream source: retire the word taken at the last posedge, present the next.
  always @(negedge clk) begin
    if (!reset) begin
      i_valid = 1'b0;
      src_acc = 0;
    end else begin
      if (src_acc) void'(src_q.pop_front());
      if (src_q.size() > 0 && $urandom_range(99, 0) < valid_pct) begin
        i_valid = 1'b1;
        i_dat   = src_q[0];
      end else begin
        i_valid = 1'b0;
        i_dat   = $urandom;
      end
      src_acc = i_valid && o_ready;
    end
  end

  // Wishbone slave and bus monitor.
  int          wait_cnt = 0;
  int          wait_target = 0;
  bit          prev_wait = 0;
  logic [31:0]  prev_adr;
  logic [127:0] prev_dat;
  always @(negedge clk) begin
    if (!reset) begin
      wb.ack = 1'b0;
      wb.err = 1'b0;
      wait_cnt = 0;
      prev_wait = 0;
    end else begin
      if (wb.cyc && wb.stb) begin
        cyc_cycles++;
        if (prev_wait) begin
          vectors++;
          if (wb.adr !== prev_adr || wb.dat !== prev_dat) begin
            miscompares++;
            $display("FAIL stable_during_wait: adr %h dat %h, held %h %h", wb.adr, wb.dat, prev_adr, prev_dat);
          end
        end
      end
      wb.ack = 1'b0;
      wb.err = 1'b0;
      if (wb.cyc && wb.stb) begin
        if (wait_cnt >= wait_target) begin
          if (slave_mode == 1) begin
            // never respond
          end else if (slave_mode == 2 && ((wb.adr - BASE) >> 4) == err_line) begin
            wb.err = 1'b1;
            wb.ack = 1'b1;
          end else begin
            wb.ack = 1'b1;
            wr_adr.push_back(wb.adr);
            wr_dat.push_back(wb.dat);
            wr_sel.push_back(wb.sel);
            wr_we.push_back(wb.we);
            $display("write adr=%h dat=%h", wb.adr, wb.dat);
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        wait_target = $urandom_range(max_delay, 0);
      end
      prev_wait = wb.cyc && wb.stb && !wb.ack && !wb.err;
      prev_adr  = wb.adr;
      prev_dat  = wb.dat;
      if (o_done) done_cnt++;
    end
  end

  function automatic logic [127:0] exp_line(input int j);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[32*k +: 32] = exp_words[4*j + k];
    return r;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    src_q.delete();
    src_acc = 0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic start_pulse(input bit mid_start);
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    if (mid_start) begin
      repeat (6) @(negedge clk);
      i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
    end
  endtask

  task automatic wait_idle(output bit timed_out);
    int n = 0;
    while (o_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    timed_out = o_busy;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_load(input bit use_index, input int vpct, input int dly,
                          input int mode, input int eline, input bit mid_start,
                          output bit to);
    valid_pct = vpct; max_delay = dly; slave_mode = mode; err_line = eline;
    src_q.delete();
    for (int i = 0; i < 4*NLINES; i++) begin
      exp_words[i] = use_index ? 32'(i) : $urandom;
      src_q.push_back(exp_words[i]);
    end
    wr_adr.delete(); wr_dat.delete(); wr_sel.delete(); wr_we.delete();
    done_cnt = 0; cyc_cycles = 0;
    start_pulse(mid_start);
    wait_idle(to);
  endtask

  task automatic test_reset();
    vectors++;
    if ({o_ready, o_busy, o_done, o_err} !== 4'b0) begin
      miscompares++; $display("FAIL reset_flags: got %b want 0000", {o_ready, o_busy, o_done, o_err});
    end
    vectors++;
    if (wb.adr !== BASE) begin miscompares++; $display("FAIL reset_adr: got %h want %h", wb.adr, BASE); end
    vectors++;
    if ({wb.cyc, wb.stb, wb.we, wb.sel} !== 19'b0) begin
      miscompares++; $display("FAIL reset_bus: cyc%b stb%b we%b sel%h want 0", wb.cyc, wb.stb, wb.we, wb.sel);
    end
    vectors++;
    if (wb.dat !== 128'b0) begin miscompares++; $display("FAIL reset_dat: got %h want 0", wb.dat); end
    vectors++;
    if ({so0, so1, so2, so3, so4} !== 5'b0) begin miscompares++; $display("FAIL reset_scan: got %b want 0", {so0, so1, so2, so3, so4}); end
    $display("test_reset done");
  endtask

  // Compares the committed writes against the first nlines lines of the model.
  task automatic check_writes(input string tag, input int nlines, input bit to,
                              input int exp_done, input logic exp_err);
    vectors++;
    if (to) begin miscompares++; $display("FAIL %s_timeout: busy still 1 after budget, want 0", tag); end
    vectors++;
    if (wr_adr.size() != nlines) begin
      miscompares++; $display("FAIL %s_count: got %0d writes want %0d", tag, wr_adr.size(), nlines);
    end
    for (int j = 0; j < nlines && j < wr_adr.size(); j++) begin
      vectors++;
      if (wr_adr[j] !== BASE + 32'(16*j) || wr_dat[j] !== exp_line(j) ||
          wr_sel[j] !== 16'hFFFF || wr_we[j] !== 1'b1) begin
        miscompares++;
        $display("FAIL %s_line%0d: adr %h dat %h sel %h we %b want %h %h FFFF 1", tag, j,
                 wr_adr[j], wr_dat[j], wr_sel[j], wr_we[j], BASE + 32'(16*j), exp_line(j));
      end
    end
    vectors++;
    if (done_cnt != exp_done) begin miscompares++; $display("FAIL %s_done: got %0d pulses want %0d", tag, done_cnt, exp_done); end
    vectors++;
    if (o_err !== exp_err) begin miscompares++; $display("FAIL %s_err: got %b want %b", tag, o_err, exp_err); end
    $display("%s: %0d writes, %0d done pulses, err=%b", tag, wr_adr.size(), done_cnt, o_err);
  endtask

  task automatic test_basic();
    bit to;
    run_load(1'b1, 100, 0, 0, 0, 1'b1, to);
    check_writes("basic", NLINES, to, 1, 1'b0);
    vectors++;
    if (wr_dat.size() > 0 && wr_dat[0] !== 128'h00000003_00000002_00000001_00000000) begin
      miscompares++; $display("FAIL basic_line0_const: got %h want 00000003000000020000000100000000", wr_dat[0]);
    end
  endtask

  task automatic test_random();
    bit to;
    for (int r = 0; r < 3; r++) begin
      run_load(1'b0, 50, 5, 0, 0, 1'b0, to);
      check_writes("random", NLINES, to, 1, 1'b0);
    end
  endtask

  task automatic test_timeout();
    bit to;
    run_load(1'b1, 100, 0, 1, 0, 1'b0, to);
    check_writes("timeout", 0, to, 0, 1'b1);
    vectors++;
    if (cyc_cycles != TMO) begin miscompares++; $display("FAIL timeout_cycles: cyc high %0d cycles want %0d", cyc_cycles, TMO); end
    run_load(1'b0, 80, 2, 0, 0, 1'b0, to);
    check_writes("timeout_restart", NLINES, to, 1, 1'b0);
  endtask

  task automatic test_bus_err();
    bit to;
    run_load(1'b0, 100, 1, 2, 2, 1'b0, to);
    check_writes("bus_err", 2, to, 0, 1'b1);
    src_q.delete();
  endtask

  task automatic test_reset_mid();
    bit to;
    int n = 0;
    valid_pct = 100; max_delay = 3; slave_mode = 0;
    src_q.delete();
    for (int i = 0; i < 4*NLINES; i++) src_q.push_back($urandom);
    wr_adr.delete(); wr_dat.delete(); wr_sel.delete(); wr_we.delete();
    start_pulse(1'b0);
    while (!(wb.cyc && wr_adr.size() == 1) && n < 500) begin
      @(negedge clk); n++;
    end
    vectors++;
    if (n >= 500) begin miscompares++; $display("FAIL midreset_reach: line1 write not seen, want within 500 cycles"); end
    #2 reset = 1'b0;
    src_q.delete();
    src_acc = 0;
    #1;
    vectors++;
    if ({wb.cyc, wb.stb, wb.we, o_busy, o_ready, o_done} !== 6'b0 || wb.sel !== 16'h0 ||
        wb.adr !== BASE || wb.dat !== 128'b0) begin
      miscompares++;
      $display("FAIL midreset_outputs: cyc%b stb%b busy%b ready%b adr %h want 0 and adr %h",
               wb.cyc, wb.stb, o_busy, o_ready, wb.adr, BASE);
    end
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    run_load(1'b0, 70, 4, 0, 0, 1'b0, to);
    check_writes("midreset_restart", NLINES, to, 1, 1'b0);
  endtask

  initial begin
    apply_reset();
    @(negedge clk);
    test_reset();
    test_basic();
    test_random();
    test_timeout();
    test_bus_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
